// File: rtl/sram_fifo.sv
// Show-ahead FIFO built on a single 1R1W SRAM. The read of the next head entry
// is issued one cycle early, so the head is always ready at the SRAM output.
// An entry written in the same cycle it becomes head is taken from a bypass
// register, so the design never relies on SRAM read-during-write behaviour.

module sram_1r1w #(
   parameter int    DATA_WIDTH        = 32,
   parameter int    SIZE              = 64,
   parameter string READ_DURING_WRITE = "DONT_CARE"
) (
   input  logic                    clk,
   input  logic                    read_en,
   input  logic [$clog2(SIZE)-1:0] read_addr,
   output logic [DATA_WIDTH-1:0]   read_data,
   input  logic                    write_en,
   input  logic [$clog2(SIZE)-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0]   write_data
);
   logic [DATA_WIDTH-1:0] mem [SIZE];

   // Synchronous write port and one-cycle-latency read port.
   always_ff @(posedge clk) begin
      if (write_en)
         mem[write_addr] <= write_data;
      if (read_en)
         read_data <= mem[read_addr];
   end
endmodule

module sram_fifo #(
   parameter int WIDTH                  = 32,
   parameter int SIZE                   = 64,
   parameter int ALMOST_FULL_THRESHOLD  = SIZE,
   parameter int ALMOST_EMPTY_THRESHOLD = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush_en,
   input  logic             enqueue_en,
   input  logic [WIDTH-1:0] enqueue_value,
   output logic             full,
   output logic             almost_full,
   input  logic             dequeue_en,
   output logic [WIDTH-1:0] dequeue_value,
   output logic             empty,
   output logic             almost_empty
);
   localparam int AW = $clog2(SIZE);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] FULL_COUNT = CW'(SIZE);
   localparam logic [CW-1:0] AF_COUNT   = CW'(ALMOST_FULL_THRESHOLD);
   localparam logic [CW-1:0] AE_COUNT   = CW'(ALMOST_EMPTY_THRESHOLD);

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    read_addr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_nxt;
   logic             bypass_sel;
   logic [WIDTH-1:0] bypass_data;
   logic [WIDTH-1:0] read_data;
   logic             write_en;

   assign write_en      = enqueue_en && !flush_en;
   assign dequeue_value = bypass_sel ? bypass_data : read_data;

   sram_1r1w #(
      .DATA_WIDTH       (WIDTH),
      .SIZE             (SIZE),
      .READ_DURING_WRITE("DONT_CARE")
   ) u_sram (
      .clk       (clk),
      .read_en   (1'b1),
      .read_addr (read_addr),
      .read_data (read_data),
      .write_en  (write_en),
      .write_addr(wr_ptr),
      .write_data(enqueue_value)
   );

   // Prefetch address (entry that is head next cycle) and next occupancy.
   always_comb begin
      read_addr = dequeue_en ? rd_ptr + AW'(1) : rd_ptr;
      count_nxt = count;
      if (flush_en)
         count_nxt = '0;
      else if (enqueue_en && !dequeue_en)
         count_nxt = count + CW'(1);
      else if (dequeue_en && !enqueue_en)
         count_nxt = count - CW'(1);
   end

   // Pointers, count, bypass capture and registered flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         bypass_sel   <= 1'b0;
         bypass_data  <= '0;
         full         <= 1'b0;
         almost_full  <= 1'b0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
      end else begin
         count        <= count_nxt;
         full         <= count_nxt == FULL_COUNT;
         almost_full  <= count_nxt >= AF_COUNT;
         empty        <= count_nxt == '0;
         almost_empty <= count_nxt <= AE_COUNT;
         if (flush_en) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            bypass_sel <= 1'b0;
         end else begin
            if (enqueue_en)
               wr_ptr <= wr_ptr + AW'(1);
            if (dequeue_en)
               rd_ptr <= read_addr;
            // Next head is being written now: SRAM read of it is not trusted.
            bypass_sel <= enqueue_en && (read_addr == wr_ptr);
            if (enqueue_en)
               bypass_data <= enqueue_value;
         end
      end
   end

   // Illegal stimulus checks.
   a_no_enq_full: assert property (@(posedge clk) disable iff (!reset_n)
      !(enqueue_en && full && !flush_en));
   a_no_deq_empty: assert property (@(posedge clk) disable iff (!reset_n)
      !(dequeue_en && empty && !flush_en));
endmodule

// File: tb/tb_sram_fifo.sv
// Self-checking bench for sram_fifo: directed vector table, then multi-cycle
// sequences (fill/drain, swap at count 1 across wrap, flush, random, reset).

module tb_sram_fifo;
   localparam int W  = 32;
   localparam int N  = 64;
   localparam int AF = 60;
   localparam int AE = 1;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         flush_en = 1'b0;
   logic         enqueue_en = 1'b0;
   logic [W-1:0] enqueue_value = '0;
   logic         full;
   logic         almost_full;
   logic         dequeue_en = 1'b0;
   logic [W-1:0] dequeue_value;
   logic         empty;
   logic         almost_empty;

   int errors = 0;
   int checks = 0;
   logic [W-1:0] q[$];

   sram_fifo #(
      .WIDTH                 (W),
      .SIZE                  (N),
      .ALMOST_FULL_THRESHOLD (AF),
      .ALMOST_EMPTY_THRESHOLD(AE)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .flush_en     (flush_en),
      .enqueue_en   (enqueue_en),
      .enqueue_value(enqueue_value),
      .full         (full),
      .almost_full  (almost_full),
      .dequeue_en   (dequeue_en),
      .dequeue_value(dequeue_value),
      .empty        (empty),
      .almost_empty (almost_empty)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         enq;
      logic [W-1:0] val;
      logic         deq;
      logic         flush;
      logic         e_empty;
      logic         e_full;
      logic         e_af;
      logic         e_ae;
      logic         chk_val;
      logic [W-1:0] e_val;
   } vec_t;

   vec_t vt[10];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, advance past the edge, update the model queue.
   task automatic cycle(input logic e, input logic [W-1:0] v, input logic d, input logic f);
      enqueue_en    = e;
      enqueue_value = v;
      dequeue_en    = d;
      flush_en      = f;
      @(posedge clk);
      #1;
      enqueue_en = 1'b0;
      dequeue_en = 1'b0;
      flush_en   = 1'b0;
      if (f)
         q.delete();
      else begin
         if (d) void'(q.pop_front());
         if (e) q.push_back(v);
      end
   endtask

   task automatic check_model(input string tag);
      int cnt;
      cnt = q.size();
      chk({tag, ".empty"}, W'(empty), W'(cnt == 0));
      chk({tag, ".full"}, W'(full), W'(cnt == N));
      chk({tag, ".almost_full"}, W'(almost_full), W'(cnt >= AF));
      chk({tag, ".almost_empty"}, W'(almost_empty), W'(cnt <= AE));
      if (cnt > 0)
         chk({tag, ".value"}, dequeue_value, q[0]);
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      //            enq  val    deq flush emp full af ae  cv  exp
      vt[0] = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11};
      vt[1] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
      vt[2] = '{1'b1, 32'hA,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA};
      vt[3] = '{1'b1, 32'hB,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hB};
      vt[4] = '{1'b1, 32'hC,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hB};
      vt[5] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hC};
      vt[6] = '{1'b1, 32'hD,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hD};
      vt[7] = '{1'b1, 32'h5,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
      vt[8] = '{1'b1, 32'h7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h7};
      vt[9] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset.empty", W'(empty), W'(1));
      chk("reset.full", W'(full), W'(0));
      chk("reset.almost_full", W'(almost_full), W'(0));
      chk("reset.almost_empty", W'(almost_empty), W'(1));
      reset_n = 1'b1;

      // Directed vector table
      for (int i = 0; i < 10; i++) begin
         cycle(vt[i].enq, vt[i].val, vt[i].deq, vt[i].flush);
         chk($sformatf("vec%0d.empty", i), W'(empty), W'(vt[i].e_empty));
         chk($sformatf("vec%0d.full", i), W'(full), W'(vt[i].e_full));
         chk($sformatf("vec%0d.almost_full", i), W'(almost_full), W'(vt[i].e_af));
         chk($sformatf("vec%0d.almost_empty", i), W'(almost_empty), W'(vt[i].e_ae));
         if (vt[i].chk_val)
            chk($sformatf("vec%0d.value", i), dequeue_value, vt[i].e_val);
      end

      // Fill with 0..N-1, then drain in order
      for (int i = 0; i < N; i++) begin
         cycle(1'b1, W'(i), 1'b0, 1'b0);
         check_model($sformatf("fill%0d", i));
      end
      chk("fill.full", W'(full), W'(1));
      chk("fill.almost_full", W'(almost_full), W'(1));
      for (int i = 0; i < N; i++) begin
         chk($sformatf("drain%0d.head", i), dequeue_value, W'(i));
         cycle(1'b0, '0, 1'b1, 1'b0);
         check_model($sformatf("drain%0d", i));
      end

      // Swap at count 1 for 200 cycles, crossing pointer wrap
      cycle(1'b1, 32'hA, 1'b0, 1'b0);
      chk("swap.init", dequeue_value, 32'hA);
      for (int k = 0; k < 200; k++) begin
         cycle(1'b1, W'(32'h100 + k), 1'b1, 1'b0);
         check_model($sformatf("swap%0d", k));
         chk($sformatf("swap%0d.head", k), dequeue_value, W'(32'h100 + k));
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
      check_model("swap.end");

      // Flush at half full with a simultaneous enqueue
      for (int i = 0; i < N / 2; i++)
         cycle(1'b1, W'(32'h200 + i), 1'b0, 1'b0);
      check_model("half");
      cycle(1'b1, 32'h5, 1'b0, 1'b1);
      chk("flush.empty", W'(empty), W'(1));
      chk("flush.full", W'(full), W'(0));
      cycle(1'b1, 32'h7, 1'b0, 1'b0);
      chk("flush.after", dequeue_value, 32'h7);
      chk("flush.after_empty", W'(empty), W'(0));
      cycle(1'b0, '0, 1'b1, 1'b0);
      check_model("flush.end");

      // Random legal traffic against the model queue
      for (int c = 0; c < 10000; c++) begin
         logic e, d, f;
         e = ($urandom_range(0, 99) < 55) && (q.size() < N);
         d = ($urandom_range(0, 99) < 50) && (q.size() > 0);
         f = ($urandom_range(0, 499) == 0);
         cycle(e, $urandom, d, f);
         check_model($sformatf("rand%0d", c));
      end

      // Asynchronous reset mid-stream
      while (q.size() > 0)
         cycle(1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++)
         cycle(1'b1, W'(32'h300 + i), 1'b0, 1'b0);
      check_model("prereset");
      #2;
      reset_n = 1'b0;
      #1;
      chk("areset.empty", W'(empty), W'(1));
      chk("areset.full", W'(full), W'(0));
      chk("areset.almost_empty", W'(almost_empty), W'(1));
      q.delete();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cycle(1'b1, 32'h3, 1'b0, 1'b0);
      chk("areset.readback", dequeue_value, 32'h3);
      check_model("areset.after");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
